// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: period encodings, control codes, guard-band words
// and the default 640x480 timing used by the period scheduler.
package hdmi_pkg;

   // HDMI period of the pixel being presented; the encoding is visible on the
   // scheduler's period port and consumed by the channel mux.
   typedef enum logic [1:0] {
      PERIOD_CONTROL  = 2'd0,
      PERIOD_PREAMBLE = 2'd1,
      PERIOD_GUARD    = 2'd2,
      PERIOD_VIDEO    = 2'd3
   } period_t;

   // CTL3..CTL0 values for the green/red control codes
   localparam logic [3:0] CTL_VIDEO_PRE = 4'b0001;
   localparam logic [3:0] CTL_IDLE      = 4'b0000;

   // Video guard-band TMDS words driven by the channel mux during GUARD
   localparam logic [9:0] GUARD_WORD_CH0 = 10'b1011001100;
   localparam logic [9:0] GUARD_WORD_CH1 = 10'b0100110011;
   localparam logic [9:0] GUARD_WORD_CH2 = 10'b1011001100;

   // Default 640x480@60 timing
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_PRE_LEN  = 8;
   localparam int DEF_GRD_LEN  = 2;

endpackage

// File: rtl/hdmi_raster_counter.sv
// Raster position counters. sx/sy are the registered position; nx/ny are the
// position that will be presented after the coming edge, so the parent can
// register decodes that line up with sx/sy without an extra stage.
module hdmi_raster_counter #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525
) (
   input  logic        clk_base,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] sx,
   output logic [10:0] sy,
   output logic [10:0] nx,
   output logic [10:0] ny
);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

   // Next position: advance one pixel when enabled, line step on column wrap
   always_comb begin
      nx = sx;
      ny = sy;
      if (en) begin
         if (sx == H_LAST) begin
            nx = 11'd0;
            ny = (sy == V_LAST) ? 11'd0 : sy + 11'd1;
         end else begin
            nx = sx + 11'd1;
         end
      end
   end

   // Position register; reset parks on the last pixel so the first advance shows (0,0)
   always_ff @(posedge clk_base or posedge rst) begin
      if (rst) begin
         sx <= H_LAST;
         sy <= V_LAST;
      end else begin
         sx <= nx;
         sy <= ny;
      end
   end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Pixel-clock sequencer for the TMDS encoder bank: raster position, syncs,
// data enable and the HDMI period (CONTROL/PREAMBLE/GUARD/VIDEO) of each pixel.
// Every output is registered from the next-position values so all of them
// describe the pixel shown on sx/sy in the same cycle. The period output is
// the period FSM state register itself.
module hdmi_period_scheduler
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int PRE_LEN  = DEF_PRE_LEN,
   parameter int GRD_LEN  = DEF_GRD_LEN
) (
   input  logic        clk_base,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] sx,
   output logic [10:0] sy,
   output logic        hsync,
   output logic        vsync,
   output logic        vde,
   output logic [1:0]  period,
   output logic [3:0]  ctl,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] HA        = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VA        = 11'(V_ACTIVE);
   localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] PRE_START = 11'(H_TOTAL - PRE_LEN - GRD_LEN);
   localparam logic [10:0] GRD_START = 11'(H_TOTAL - GRD_LEN);
   localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);

   logic [10:0] nx, ny, nl;
   period_t     state, state_nx;
   logic        hsync_nx, vsync_nx, vde_nx, fs_nx;
   logic [3:0]  ctl_nx;

   hdmi_raster_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_raster (
      .clk_base (clk_base),
      .rst      (rst),
      .en       (en),
      .sx       (sx),
      .sy       (sy),
      .nx       (nx),
      .ny       (ny)
   );

   // Line that follows the one being presented; preamble is only scheduled
   // at the end of a line when that following line carries video.
   assign nl = (ny == V_LAST) ? 11'd0 : ny + 11'd1;

   // Period FSM next state plus decodes for the pixel (nx, ny).
   // CONTROL -> VIDEO at column 0 covers the first active line after reset,
   // which has no preceding preamble.
   always_comb begin
      state_nx = state;
      if (en) begin
         unique case (state)
            PERIOD_CONTROL: begin
               if ((nx == PRE_START) && (nl < VA))
                  state_nx = PERIOD_PREAMBLE;
               else if ((nx == 11'd0) && (ny < VA))
                  state_nx = PERIOD_VIDEO;
            end
            PERIOD_PREAMBLE: if (nx == GRD_START) state_nx = PERIOD_GUARD;
            PERIOD_GUARD:    if (nx == 11'd0)     state_nx = PERIOD_VIDEO;
            PERIOD_VIDEO:    if (nx == HA)        state_nx = PERIOD_CONTROL;
         endcase
      end
      hsync_nx = (nx >= HS_START) && (nx < HS_END);
      vsync_nx = (ny >= VS_START) && (ny < VS_END);
      vde_nx   = (nx < HA) && (ny < VA);
      ctl_nx   = (state_nx == PERIOD_PREAMBLE) ? CTL_VIDEO_PRE : CTL_IDLE;
      fs_nx    = en && (nx == 11'd0) && (ny == 11'd0);
   end

   // Output and state registers; frozen values follow from nx/ny holding when en=0
   always_ff @(posedge clk_base or posedge rst) begin
      if (rst) begin
         state       <= PERIOD_CONTROL;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         vde         <= 1'b0;
         ctl         <= CTL_IDLE;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         hsync       <= hsync_nx;
         vsync       <= vsync_nx;
         vde         <= vde_nx;
         ctl         <= ctl_nx;
         frame_start <= fs_nx;
      end
   end

   assign period = state;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler on a reduced raster (80x21 total) so whole
// frames fit in a short run. Geometry: hsync 48..59, vsync lines 15..16,
// preamble columns 70..77, guard 78..79, frame length 1680 pixels.
module tb_hdmi_period_scheduler;

   localparam int HA = 40, HF = 8, HS = 12, HB = 20;
   localparam int VA = 12, VF = 3, VS = 2, VB = 4;
   localparam int PRE = 8, GRD = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   // ---------------- clock / reset / DUT ----------------
   logic        clk_base = 1'b0;
   logic        rst;
   logic        en;
   logic [10:0] sx, sy;
   logic        hsync, vsync, vde;
   logic [1:0]  period;
   logic [3:0]  ctl;
   logic        frame_start;

   always #5 clk_base = ~clk_base;

   hdmi_period_scheduler #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .PRE_LEN  (PRE), .GRD_LEN (GRD)
   ) dut (
      .clk_base    (clk_base),
      .rst         (rst),
      .en          (en),
      .sx          (sx),
      .sy          (sy),
      .hsync       (hsync),
      .vsync       (vsync),
      .vde         (vde),
      .period      (period),
      .ctl         (ctl),
      .frame_start (frame_start)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          adv_q[$];

   function automatic logic [31:0] pk(int x, int y, logic hs, logic vs, logic de,
                                      logic [1:0] p, logic [3:0] c, logic fs);
      return {11'(x), 11'(y), hs, vs, de, p, c, fs};
   endfunction

   function automatic string fmt(logic [31:0] v);
      return $sformatf("sx=%0d sy=%0d hs=%0b vs=%0b de=%0b per=%0d ctl=%b fs=%0b",
                       v[31:21], v[20:10], v[9], v[8], v[7], v[6:5], v[4:1], v[0]);
   endfunction

   task automatic check(input string name, input logic [31:0] exp);
      logic [31:0] act;
      act = {sx, sy, hsync, vsync, vde, period, ctl, frame_start};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %s expected %s", name, fmt(act), fmt(exp));
      end
   endtask

   // Independent coordinate-based reference for the sweep
   function automatic logic [31:0] ref_pix(int x, int y);
      int         nl;
      logic [1:0] p;
      nl = (y == VT - 1) ? 0 : y + 1;
      if (x < HA && y < VA)                               p = 2'd3;
      else if (nl < VA && x >= HT - PRE - GRD && x < HT - GRD) p = 2'd1;
      else if (nl < VA && x >= HT - GRD)                  p = 2'd2;
      else                                                p = 2'd0;
      return pk(x, y, (x >= 48 && x < 60), (y >= 15 && y < 17), (x < HA && y < VA),
                p, (p == 2'd1) ? 4'b0001 : 4'b0000, (x == 0 && y == 0));
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_base);
      #1;
   endtask

   task automatic run(input int n);
      en = 1'b1;
      repeat (n) tick();
   endtask

   task automatic add(input int adv, input logic [31:0] exp);
      adv_q.push_back(adv);
      exp_q.push_back(exp);
   endtask

   // period==VIDEO must coincide with vde at every pixel
   always @(negedge clk_base) begin
      checks++;
      if ((period === 2'd3) !== (vde === 1'b1)) begin
         errors++;
         $display("FAIL video_iff_vde: period=%0d vde=%0b at sx=%0d sy=%0d", period, vde, sx, sy);
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int x, y, since, pulses;

      // Vector table: advance count, then expected outputs; starts from (0,0)
      add(39,  pk(39, 0, 0, 0, 1, 3, 4'b0000, 0));
      add(1,   pk(40, 0, 0, 0, 0, 0, 4'b0000, 0));
      add(8,   pk(48, 0, 1, 0, 0, 0, 4'b0000, 0));
      add(11,  pk(59, 0, 1, 0, 0, 0, 4'b0000, 0));
      add(1,   pk(60, 0, 0, 0, 0, 0, 4'b0000, 0));
      add(10,  pk(70, 0, 0, 0, 0, 1, 4'b0001, 0));
      add(7,   pk(77, 0, 0, 0, 0, 1, 4'b0001, 0));
      add(1,   pk(78, 0, 0, 0, 0, 2, 4'b0000, 0));
      add(1,   pk(79, 0, 0, 0, 0, 2, 4'b0000, 0));
      add(1,   pk(0,  1, 0, 0, 1, 3, 4'b0000, 0));
      add(790, pk(70, 10, 0, 0, 0, 1, 4'b0001, 0));
      add(10,  pk(0,  11, 0, 0, 1, 3, 4'b0000, 0));
      add(70,  pk(70, 11, 0, 0, 0, 0, 4'b0000, 0));
      add(10,  pk(0,  12, 0, 0, 0, 0, 4'b0000, 0));
      add(240, pk(0,  15, 0, 1, 0, 0, 4'b0000, 0));
      add(159, pk(79, 16, 0, 1, 0, 0, 4'b0000, 0));
      add(1,   pk(0,  17, 0, 0, 0, 0, 4'b0000, 0));
      add(310, pk(70, 20, 0, 0, 0, 1, 4'b0001, 0));
      add(8,   pk(78, 20, 0, 0, 0, 2, 4'b0000, 0));
      add(2,   pk(0,  0,  0, 0, 1, 3, 4'b0000, 1));

      // Asynchronous reset, checked before any clock edge
      rst = 1'b0;
      en  = 1'b0;
      #2 rst = 1'b1;
      #1 check("reset_async", pk(HT - 1, VT - 1, 0, 0, 0, 0, 4'b0000, 0));
      tick();
      check("reset_held", pk(HT - 1, VT - 1, 0, 0, 0, 0, 4'b0000, 0));
      @(negedge clk_base);
      rst = 1'b0;
      en  = 1'b1;
      tick();
      check("first_pixel", pk(0, 0, 0, 0, 1, 3, 4'b0000, 1));
      en = 1'b0;
      tick();
      check("hold_origin", pk(0, 0, 0, 0, 1, 3, 4'b0000, 0));

      // Table-driven walk through line 0, line ends, vertical blanking and wrap
      for (int i = 0; i < adv_q.size(); i++) begin
         run(adv_q[i]);
         check($sformatf("vec%0d", i), exp_q[i]);
      end

      // Full-frame sweep against the coordinate reference, frame_start spacing
      x = 0; y = 0; since = 0; pulses = 0;
      en = 1'b1;
      repeat (HT * VT) begin
         tick();
         since++;
         if (x == HT - 1) begin
            x = 0;
            y = (y == VT - 1) ? 0 : y + 1;
         end else begin
            x++;
         end
         check("sweep", ref_pix(x, y));
         if (frame_start === 1'b1) begin
            pulses++;
            checks++;
            if (since != HT * VT) begin
               errors++;
               $display("FAIL frame_interval: got %0d cycles expected %0d", since, HT * VT);
            end
            since = 0;
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL frame_pulses: got %0d expected 1", pulses);
      end

      // Freeze inside the preamble, then resume into the guard band
      run(2 * HT + 77);
      check("pre_before_hold", pk(77, 2, 0, 0, 0, 1, 4'b0001, 0));
      en = 1'b0;
      repeat (37) begin
         tick();
         check("pre_frozen", pk(77, 2, 0, 0, 0, 1, 4'b0001, 0));
      end
      run(1);
      check("resume_guard", pk(78, 2, 0, 0, 0, 2, 4'b0000, 0));

      // Mid-frame reset, asserted between edges
      run(192);
      check("mid_frame", pk(30, 5, 0, 0, 1, 3, 4'b0000, 0));
      #2 rst = 1'b1;
      #1 check("reset_mid_async", pk(HT - 1, VT - 1, 0, 0, 0, 0, 4'b0000, 0));
      tick();
      check("reset_mid_held", pk(HT - 1, VT - 1, 0, 0, 0, 0, 4'b0000, 0));
      @(negedge clk_base);
      rst = 1'b0;
      tick();
      check("restart_pixel", pk(0, 0, 0, 0, 1, 3, 4'b0000, 1));
      run(HA);
      check("restart_line0_end", pk(HA, 0, 0, 0, 0, 0, 4'b0000, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Run-length guard
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule
